// File: rtl/mmio_io_responder.sv
// Memory-mapped IO responder: LED register, debounced switch input channel,
// valid/ready output channel toward the display driver, and a cycle counter.
module mmio_io_responder #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    input  logic        io_rd,
    output logic [31:0] io_din,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led,
    output logic [31:0] seg_data,
    output logic        seg_valid,
    input  logic        seg_ready
);

    localparam logic [7:0] ADDR_LED        = 8'h00;
    localparam logic [7:0] ADDR_IN_STATUS  = 8'h04;
    localparam logic [7:0] ADDR_IN_DATA    = 8'h08;
    localparam logic [7:0] ADDR_OUT_STATUS = 8'h0C;
    localparam logic [7:0] ADDR_OUT_DATA   = 8'h10;
    localparam logic [7:0] ADDR_CYCLE      = 8'h14;

    localparam logic [19:0] DB_LIMIT = 20'(DEBOUNCE_CYCLES);

    logic [15:0] sw_meta;
    logic [15:0] sw_sync;
    logic        btn_meta;
    logic        btn_sync;
    logic [19:0] db_cnt;
    logic        btn_db;
    logic        btn_db_q;

    logic [15:0] in_data;
    logic        in_valid;
    logic        in_overrun;
    logic        out_drop;
    logic [31:0] cycle_cnt;

    logic wr_led;
    logic wr_in_status;
    logic wr_out_status;
    logic wr_out_data;
    logic pop;
    logic btn_rise;
    logic slot_free;
    logic handshake;

    assign wr_led        = io_we && (io_addr == ADDR_LED);
    assign wr_in_status  = io_we && (io_addr == ADDR_IN_STATUS);
    assign wr_out_status = io_we && (io_addr == ADDR_OUT_STATUS);
    assign wr_out_data   = io_we && (io_addr == ADDR_OUT_DATA);
    assign pop           = io_rd && (io_addr == ADDR_IN_DATA);

    assign btn_rise  = btn_db & ~btn_db_q;
    assign handshake = seg_valid & seg_ready;
    assign slot_free = ~seg_valid | seg_ready;

    // Synchronizers and debouncer; btn_db only moves after DB_LIMIT stable cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
            btn_db_q <= btn_db;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt + 20'd1 == DB_LIMIT) begin
                btn_db <= ~btn_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 20'd1;
            end
        end
    end

    // A capture coinciding with a pop refills the slot rather than overrunning
    always_ff @(posedge clk) begin
        if (rst) begin
            in_data    <= '0;
            in_valid   <= 1'b0;
            in_overrun <= 1'b0;
        end else begin
            if (btn_rise && (!in_valid || pop)) begin
                in_data  <= sw_sync;
                in_valid <= 1'b1;
            end else if (pop) begin
                in_valid <= 1'b0;
            end

            if (btn_rise && in_valid && !pop) begin
                in_overrun <= 1'b1;
            end else if (wr_in_status && io_dout[1]) begin
                in_overrun <= 1'b0;
            end
        end
    end

    // Output slot: a write is accepted when empty or draining on this same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_data  <= '0;
            seg_valid <= 1'b0;
            out_drop  <= 1'b0;
        end else begin
            if (wr_out_data) begin
                if (slot_free) begin
                    seg_data  <= io_dout;
                    seg_valid <= 1'b1;
                end else begin
                    out_drop <= 1'b1;
                end
            end else if (handshake) begin
                seg_valid <= 1'b0;
            end

            if (wr_out_status && io_dout[1]) begin
                out_drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= '0;
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_led) begin
                led <= io_dout[15:0];
            end
        end
    end

    // Read data is purely combinational so the CPU captures it on the same edge
    always_comb begin
        io_din = '0;
        case (io_addr)
            ADDR_LED:        io_din = {16'b0, led};
            ADDR_IN_STATUS:  io_din = {30'b0, in_overrun, in_valid};
            ADDR_IN_DATA:    io_din = {16'b0, in_data};
            ADDR_OUT_STATUS: io_din = {30'b0, out_drop, ~seg_valid};
            ADDR_OUT_DATA:   io_din = seg_data;
            ADDR_CYCLE:      io_din = cycle_cnt;
            default:         io_din = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed scoreboard bench for mmio_io_responder with a short debounce window.
module tb_mmio_io_responder;

    localparam int DB = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;
    logic [15:0] sw;
    logic        btn;
    logic [15:0] led;
    logic [31:0] seg_data;
    logic        seg_valid;
    logic        seg_ready;

    logic        probe;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int checks;
    int errors;

    mmio_io_responder #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .io_addr   (io_addr),
        .io_dout   (io_dout),
        .io_we     (io_we),
        .io_rd     (io_rd),
        .io_din    (io_din),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .seg_data  (seg_data),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: any cycle with a load or a probe consumes one scoreboard entry
    always @(negedge clk) begin
        if (!rst && (io_rd || probe)) begin
            if (sb_q.size() == 0) begin
                checkOutput("scoreboard_underflow", 32'h1, 32'h0);
            end else begin
                sb_item_t it;
                logic [31:0] act;
                it = sb_q.pop_front();
                case (it.sel)
                    0:       act = io_din;
                    1:       act = {16'b0, led};
                    2:       act = {31'b0, seg_valid};
                    default: act = seg_data;
                endcase
                checkOutput(it.name, act, it.exp);
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic rd, input logic [7:0] addr, input logic [31:0] data);
        io_we   = we;
        io_rd   = rd;
        io_addr = addr;
        io_dout = data;
        @(posedge clk);
        #1;
        io_we = 1'b0;
        io_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic writeReg(input logic [7:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, data);
    endtask

    task automatic readExpect(input logic [7:0] addr, input logic [31:0] exp, input string name);
        sb_item_t it;
        it.name = name;
        it.sel  = 0;
        it.exp  = exp;
        sb_q.push_back(it);
        applyStimulus(1'b0, 1'b1, addr, 32'h0);
    endtask

    task automatic probeExpect(input int sel, input logic [31:0] exp, input string name);
        sb_item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        sb_q.push_back(it);
        probe = 1'b1;
        idle(1);
        probe = 1'b0;
    endtask

    task automatic pressRelease();
        btn = 1'b1;
        idle(10);
        btn = 1'b0;
        idle(10);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        probe     = 1'b0;
        rst       = 1'b1;
        io_addr   = '0;
        io_dout   = '0;
        io_we     = 1'b0;
        io_rd     = 1'b0;
        sw        = '0;
        btn       = 1'b0;
        seg_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        readExpect(8'h00, 32'h0, "rst_led");
        readExpect(8'h04, 32'h0, "rst_in_status");
        readExpect(8'h08, 32'h0, "rst_in_data");
        readExpect(8'h0C, 32'h1, "rst_out_status");
        readExpect(8'h14, 32'd4, "rst_cycle");
        readExpect(8'h20, 32'h0, "rst_unmapped");
        probeExpect(2, 32'h0, "rst_seg_valid");
        probeExpect(1, 32'h0, "rst_led_pin");

        $display("[TB] LED register");
        writeReg(8'h00, 32'h1234ABCD);
        probeExpect(1, 32'h0000ABCD, "led_pin");
        readExpect(8'h00, 32'h0000ABCD, "led_read");
        writeReg(8'h20, 32'hFFFFFFFF);
        readExpect(8'h00, 32'h0000ABCD, "unmapped_write_ignored");

        $display("[TB] input channel");
        sw  = 16'h00A5;
        btn = 1'b1;
        idle(2);
        btn = 1'b0;
        idle(10);
        readExpect(8'h04, 32'h0, "glitch_no_capture");

        btn = 1'b1;
        idle(6);
        readExpect(8'h04, 32'h0, "btn_latency_edge6");
        readExpect(8'h04, 32'h1, "btn_latency_edge7");
        readExpect(8'h08, 32'h00A5, "in_data_pop");
        readExpect(8'h04, 32'h0, "after_pop_status");
        btn = 1'b0;
        idle(10);

        pressRelease();
        sw = 16'h000F;
        pressRelease();
        readExpect(8'h04, 32'h3, "overrun_status");
        writeReg(8'h04, 32'h2);
        readExpect(8'h04, 32'h1, "overrun_cleared");
        readExpect(8'h08, 32'h00A5, "overrun_data_kept");
        readExpect(8'h04, 32'h0, "overrun_popped");

        $display("[TB] output channel");
        writeReg(8'h10, 32'h11);
        readExpect(8'h0C, 32'h0, "out_busy");
        probeExpect(2, 32'h1, "seg_valid_set");
        writeReg(8'h10, 32'h22);
        probeExpect(3, 32'h11, "seg_data_held");
        readExpect(8'h0C, 32'h2, "out_drop_set");
        readExpect(8'h10, 32'h11, "out_data_read");
        writeReg(8'h0C, 32'h2);
        readExpect(8'h0C, 32'h0, "out_drop_cleared");

        seg_ready = 1'b1;
        writeReg(8'h10, 32'h33);
        seg_ready = 1'b0;
        probeExpect(3, 32'h33, "write_with_handshake_data");
        probeExpect(2, 32'h1, "write_with_handshake_valid");
        readExpect(8'h0C, 32'h0, "write_with_handshake_nodrop");

        seg_ready = 1'b1;
        idle(1);
        seg_ready = 1'b0;
        probeExpect(2, 32'h0, "handshake_clears_valid");
        readExpect(8'h0C, 32'h1, "handshake_slot_free");

        $display("[TB] pop and capture on the same edge");
        sw = 16'h0011;
        pressRelease();
        sw  = 16'h005A;
        btn = 1'b1;
        idle(6);
        readExpect(8'h08, 32'h0011, "pop_capture_old");
        readExpect(8'h04, 32'h1, "pop_capture_status");
        readExpect(8'h08, 32'h005A, "pop_capture_new");
        readExpect(8'h04, 32'h0, "pop_capture_drained");
        btn = 1'b0;
        idle(10);

        $display("[TB] reset with pending output");
        writeReg(8'h10, 32'h44);
        probeExpect(2, 32'h1, "pending_valid");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        probeExpect(2, 32'h0, "reset_seg_valid");
        probeExpect(3, 32'h0, "reset_seg_data");
        probeExpect(1, 32'h0, "reset_led");
        readExpect(8'h0C, 32'h1, "reset_out_status");

        idle(2);
        if (sb_q.size() != 0) checkOutput("scoreboard_leftover", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_io_responder.md
# mmio_io_responder

Memory-mapped peripheral responder on the CPU's 8-bit IO bus, selected whenever the data address is ≥ 0xFF00.
- Decodes `io_addr` and serves loads/stores from the MEM stage: LED register, debounced switch-input channel with valid/overrun status, and a valid/ready output channel toward the seven-segment display driver.
- Also provides a free-running cycle counter.
- Read data is combinational so the CPU can capture it into its MEM/WB register on the same edge.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required before the debounced button changes state. Legal range 1..2^20−1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `io_addr`  in  8  register address (byte address, word-aligned)
- `io_dout`  in  32  store data from CPU
- `io_we`  in  1  store strobe, one cycle per store
- `io_rd`  in  1  load strobe, one cycle per load
- `io_din`  out  32  load data to CPU, combinational from `io_addr`
- `sw`  in  16  raw board switches (asynchronous)
- `btn`  in  1  raw "input valid" push button (asynchronous, bouncy)
- `led`  out  16  LED register
- `seg_data`  out  32  output word to display driver
- `seg_valid`  out  1  `seg_data` valid
- `seg_ready`  in  1  display driver accepts the word

## Operation
Register map (word offsets; unmapped: read 0, write ignored):
- 0x00 LED (R/W): write loads `led <= io_dout[15:0]`; read returns zero-extended `led`.
- 0x04 IN_STATUS (R/W): read `{30'b0, in_overrun, in_valid}`; write with `io_dout[1]=1` clears `in_overrun`.
- 0x08 IN_DATA (R): read returns zero-extended `in_data`; `io_rd` at this address clears `in_valid` (pop).
- 0x0C OUT_STATUS (R/W): read `{30'b0, out_drop, ~seg_valid}`; write with `io_dout[1]=1` clears `out_drop`.
- 0x10 OUT_DATA (W): if the slot is free, `seg_data <= io_dout` and `seg_valid <= 1`; otherwise ignored and `out_drop <= 1`. Read returns `seg_data`.
- 0x14 CYCLE (R): 32-bit free-running counter, wraps 0xFFFFFFFF→0. Writes ignored.

Input channel:
- `sw` and `btn` each pass through a 2-flop synchronizer.
- Debouncer: 20-bit counter. Reset to 0 whenever `btn_sync == btn_db`. Otherwise it increments; on reaching `DEBOUNCE_CYCLES`, `btn_db` toggles and the counter clears.
- Rising edge of `btn_db`:
  - if `in_valid=0`: capture `in_data <= sw_sync` and set `in_valid`.
  - if `in_valid=1`: data is kept and `in_overrun <= 1`.
- Pop and capture on the same edge: capture wins. New data is loaded, `in_valid` stays 1, no overrun.

Output channel:
- Slot is free when `seg_valid=0`, or when `seg_valid & seg_ready` on this edge (handshake completes).
- Handshake alone: `seg_valid <= 0`.
- Write plus handshake on the same edge: new word is loaded, `seg_valid` stays 1, no drop.
- `seg_data` is held stable while `seg_valid=1`.

Strobes:
- `io_we` and `io_rd` are never both asserted.
- A load with no side effect (any address other than 0x08) changes no state.

## Timing
- Reset (synchronous, wins over all strobes): `led=0`, `seg_data=0`, `seg_valid=0`, `in_valid=0`, `in_overrun=0`, `out_drop=0`, `in_data=0`, cycle counter 0, debounce counter 0, `btn_db=0`, synchronizers 0.
- After reset, `io_din` reads 0 at every address except 0x0C, which reads 1.
- Writes take effect at the edge where `io_we=1` and are visible on `io_din` the following cycle.
- Loads: `io_din` is valid in the same cycle as `io_rd`, zero-cycle latency. The pop side effect occurs at that edge.
- Button latency: raw `btn` rise held stable → `in_valid=1` after 2 + `DEBOUNCE_CYCLES` + 1 cycles.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no capture.
- `sw` is sampled at the same edge that sets `in_valid`, from its 2-cycle-delayed synchronized value.
- Reset asserted mid-debounce or mid-handshake: all state clears on that edge; a pending output word is discarded.

## Test plan
- Reset, then read 0x00/0x04/0x08/0x0C/0x14/0x20 → 0, 0, 0, 1, counter value, 0. `seg_valid=0`, `led=0`.
- Store 0x1234ABCD to 0x00 → `led=0xABCD` the next cycle; load 0x00 → 0x0000ABCD.
- `DEBOUNCE_CYCLES=4`, `sw=0x00A5`:
  - 2-cycle `btn` glitch → no capture.
  - `btn` held → `in_valid=1` exactly 7 cycles later; read 0x08 → 0xA5 and the next read of 0x04 → 0.
  - Second press without pop → 0x04 reads 3 and 0x08 still returns 0xA5.
  - Write 0x04 with value 2 → reads 1.
- `seg_ready=0`: store 0x11 to 0x10 → `seg_valid=1`, 0x0C reads 0. Store 0x22 → `seg_data` stays 0x11, 0x0C reads 2.
- `seg_ready=1` during a store of 0x33 with `seg_valid=1` → `seg_data=0x33`, `seg_valid` stays 1, no drop.
- Pop of 0x08 on the same edge as a debounced rise with `sw=0x5A` → `in_valid=1`, `in_data=0x5A`, overrun 0. Assert `rst` with `seg_valid=1` → `seg_valid=0` next cycle.
